// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and dmem_responder.
// The master drives the request side; the slave returns data and status.
interface dmem_responder_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output addr, rd, wr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  addr, rd, wr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MEM stage: each request is held for LATENCY wait states.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag and neutralise accesses with addr >= NMEM.
module dmem_responder #(
    parameter int NMEM    = 128,
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    dmem_responder_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic                wr_op_reg;
    logic [31:0]         rdata_reg;
    logic                err_reg;
    logic                accept;
    logic                commit;
    logic                in_range;
    logic                req_out_of_range;

    logic [31:0]         mem [NMEM];

`ifdef DMEM_RANGE_CHECK_EN
    assign in_range         = (int'(addr_reg) < NMEM);
    assign req_out_of_range = (int'(bus.addr) >= NMEM);
`else
    assign in_range         = 1'b1;
    assign req_out_of_range = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.rd || bus.wr) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured once at acceptance; bus changes during WAIT are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            wr_op_reg <= 1'b0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg  <= bus.addr;
                wdata_reg <= bus.wdata;
                wr_op_reg <= bus.wr;
                cnt_reg   <= 4'(LATENCY - 1);
                if ((bus.rd && bus.wr) || req_out_of_range)
                    err_reg <= 1'b1;
            end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (commit && !wr_op_reg)
                rdata_reg <= in_range ? mem[addr_reg] : 32'd0;
        end
    end

    // Memory array has no reset so it maps onto block RAM and survives rst.
    always_ff @(posedge clk) begin
        if (commit && wr_op_reg && in_range)
            mem[addr_reg] <= wdata_reg;
    end

    assign bus.busy  = (state_reg == IDLE && (bus.rd || bus.wr)) || (state_reg == WAIT);
    assign bus.done  = (state_reg == DONE);
    assign bus.rdata = rdata_reg;
    assign bus.err   = err_reg;
endmodule
